// File: rtl/systema_timer_multi_if.sv
// Avalon-MM slave bus bundle for systema_timer_multi.
//   chipselect  slave select
//   write_n     active-low write strobe
//   address     word address {channel, reg[1:0]}
//   writedata   write data
//   readdata    registered read data (driven by the slave)
interface systema_timer_multi_if #(
  parameter int ADDR_W = 3
);
  logic              chipselect;
  logic              write_n;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output chipselect, write_n, address, writedata, input readdata);
  modport slave  (input chipselect, write_n, address, writedata, output readdata);
endinterface

// File: rtl/systema_timer_multi.sv
// Multi-channel interval timer on an Avalon-MM slave.
// NUM_CH independent CNT_W-bit down-counters, each with period, snapshot,
// status (RUN, TO) and control (ITO, CONT, START/STOP pulses).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           Avalon-MM slave (address = {channel, reg[1:0]})
//   irq           OR of all channel interrupts
//   irq_vec       per-channel interrupt, bit i = TO_i & ITO_i

// One timer channel. Write strobes arrive already decoded.
module systema_timer_multi_ch #(
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_status,
  input  logic             wr_ctrl,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic [CNT_W-1:0] wdata,
  input  logic [3:0]       ctrl,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] snap,
  output logic             to,
  output logic             run,
  output logic             ito,
  output logic             cont
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             timeout;
  logic             start;
  logic             stop;

  // A period write force-reloads the counter and suppresses the timeout.
  assign timeout = run && (cnt == '0) && !wr_period;
  assign start   = wr_ctrl && ctrl[2];
  assign stop    = wr_ctrl && ctrl[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= DEF;
      period <= DEF;
      snap   <= '0;
      to     <= 1'b0;
      run    <= 1'b0;
      ito    <= 1'b0;
      cont   <= 1'b0;
    end else begin
      if (wr_period) begin
        period <= wdata;
        cnt    <= wdata;
      end else if (timeout) begin
        cnt <= period;
      end else if (run) begin
        cnt <= cnt - 1'b1;
      end

      // Timeout beats a same-cycle clear so no event is lost.
      if (timeout)        to <= 1'b1;
      else if (wr_status) to <= 1'b0;

      // STOP beats START; software control beats one-shot auto-stop.
      if (stop)         run <= 1'b0;
      else if (start)   run <= 1'b1;
      else if (timeout) run <= cont;

      if (wr_ctrl) begin
        ito  <= ctrl[0];
        cont <= ctrl[1];
      end

      // Captures the pre-update counter value.
      if (wr_snap) snap <= cnt;
    end
  end
endmodule

module systema_timer_multi #(
  parameter int NUM_CH         = 2,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 49999
) (
  input  logic                 clk,
  input  logic                 reset_n,
  systema_timer_multi_if.slave bus,
  output logic                 irq,
  output logic [NUM_CH-1:0]    irq_vec
);
  localparam int ADDR_W = $clog2(NUM_CH) + 2;
  localparam int CH_W   = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [ADDR_W-1:0] addr;
  logic [1:0]        rsel;
  logic [CH_W-1:0]   ch;
  logic              wr;
  logic [31:0]       rd_next;
  logic              unused_bits;

  logic [NUM_CH-1:0][CNT_W-1:0] period;
  logic [NUM_CH-1:0][CNT_W-1:0] snap;
  logic [NUM_CH-1:0]            to;
  logic [NUM_CH-1:0]            run;
  logic [NUM_CH-1:0]            ito;
  logic [NUM_CH-1:0]            cont;

  assign addr        = bus.address;
  assign rsel        = addr[1:0];
  assign wr          = bus.chipselect && !bus.write_n;
  assign unused_bits = ^bus.writedata;

  generate
    if (ADDR_W > 2) begin : g_ch
      assign ch = addr[ADDR_W-1:2];
    end else begin : g_ch0
      assign ch = '0;
    end
  endgenerate

  // Channel indices >= NUM_CH match no lane, so such writes fall away.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    logic hit;
    assign hit = wr && (ch == CH_W'(g));

    systema_timer_multi_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_status (hit && (rsel == 2'd0)),
      .wr_ctrl   (hit && (rsel == 2'd1)),
      .wr_period (hit && (rsel == 2'd2)),
      .wr_snap   (hit && (rsel == 2'd3)),
      .wdata     (bus.writedata[CNT_W-1:0]),
      .ctrl      (bus.writedata[3:0]),
      .period    (period[g]),
      .snap      (snap[g]),
      .to        (to[g]),
      .run       (run[g]),
      .ito       (ito[g]),
      .cont      (cont[g])
    );
  end

  assign irq_vec = to & ito;
  assign irq     = |irq_vec;

  // Read mux follows the address every cycle; out-of-range channels read 0.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) begin
        case (rsel)
          2'd0:    rd_next[1:0]       = {run[i], to[i]};
          2'd1:    rd_next[1:0]       = {cont[i], ito[i]};
          2'd2:    rd_next[CNT_W-1:0] = period[i];
          default: rd_next[CNT_W-1:0] = snap[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_next;
  end
endmodule
